// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle control FSM for the MIPS datapath.
// It runs fetch, decode, execute, memory and writeback over several clocks so that a
// single memory can hold both instructions and data.
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   run                   start/continue execution (sampled in IDLE and at completion)
//   opcode[5:0]           instruction bits [31:26] from the instruction register
//   mem_ready             memory finished the current access this cycle
//   iord .. branch        datapath selects and enables (Moore, decoded from state)
//   illegal_op            unknown opcode seen in DECODE
//   halted                FSM is in IDLE
//   state[3:0]            current state encoding, for debug
//   instr_count[CNT_W-1:0] retired legal instructions, wraps modulo 2^CNT_W
module mc_sequencer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             pc_write,
    output logic             branch,
    output logic             illegal_op,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             complete_c;
    logic             legal_c;

    // Opcodes this sequencer knows how to run.
    always_comb begin
        legal_c = 1'b0;
        case (opcode)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal_c = 1'b1;
            default:                                       legal_c = 1'b0;
        endcase
    end

    // Next-state and retired-instruction counter logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        complete_c = 1'b0;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    // Illegal: skip the instruction without retiring it.
                    default:      state_d = run ? S_FETCH : S_IDLE;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  complete_c = 1'b1;
            S_MEMWR:  complete_c = mem_ready;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  complete_c = 1'b1;
            S_BRANCH: complete_c = 1'b1;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: complete_c = 1'b1;
            S_JUMP:   complete_c = 1'b1;
            default:  state_d = S_IDLE;
        endcase
        if (complete_c) begin
            count_d = count_q + CNT_W'(1);
            state_d = run ? S_FETCH : S_IDLE;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Moore control decode; ir_write/pc_write in FETCH fire only on the ready cycle
    // so the IR and PC update exactly once per fetch.
    always_comb begin
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = ~legal_c;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted      = (state_q == S_IDLE);
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multicycle control FSM for the MIPS datapath. Replaces the single-cycle ControlUnit.
- Sequences fetch, decode, execute, memory and writeback over several clocks so one shared memory serves both instructions and data.
- Waits on a memory-ready handshake, supports run/halt, and counts retired instructions.
- Sits beside the register file, ALU, ALU_CNTRL and memory muxes; drives all of their select and enable lines.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  start/continue execution.
- opcode  input  6  instruction bits [31:26] from the instruction register.
- mem_ready  input  1  memory has completed the current read/write this cycle.
- iord  output  1  memory address select: 0 = PC, 1 = ALU result register.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- ir_write  output  1  instruction register load.
- reg_dst  output  1  write-register select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write-data select: 0 = ALU, 1 = memory data register.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- alu_op  output  2  to ALU_CNTRL: 00 = add, 01 = sub, 10 = funct field.
- pc_src  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- pc_write  output  1  unconditional PC write.
- branch  output  1  PC write qualified by the zero flag.
- illegal_op  output  1  unknown opcode seen in DECODE.
- halted  output  1  FSM is in IDLE.
- state  output  4  current state encoding, for debug.
- instr_count  output  CNT_W  number of retired legal instructions.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12. Codes 13-15 go to IDLE on the next clock.
- Reset (rst_n=0, asynchronous): state=IDLE, instr_count=0. All control outputs are 0 except halted=1.
- Control outputs are Moore, decoded from state; any output not listed for a state is 0.
- IDLE: all controls 0. Go to FETCH when run=1.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 0x23 (lw) or 0x2B (sw) -> MEMADR
  - 0x00 (R-type) -> EXEC
  - 0x04 (beq) -> BRANCH
  - 0x08 (addi) -> ADDIEX
  - 0x02 (j) -> JUMP
  - any other opcode: illegal_op=1 for this one cycle, then go to the completion target (below) without incrementing instr_count.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1. Stay until mem_ready=1, then go to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Completes.
- MEMWR: iord=1, mem_write=1. Stay until mem_ready=1, then complete.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Completes.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. Completes.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Completes.
- JUMP: pc_src=10, pc_write=1. Completes.
- Completion:
  - instr_count increments by 1 on the completing edge; it wraps modulo 2^CNT_W.
  - Next state is FETCH if run=1, otherwise IDLE.
  - run is sampled only at completion and in IDLE; dropping run mid-instruction lets the instruction finish.
- Latency with mem_ready held at 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
  - each cycle with mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
- Waiting in FETCH/MEMRD/MEMWR: mem_read/mem_write/iord stay asserted and stable.
- Reset asserted mid-instruction: immediate return to IDLE with reset values; no partial writeback occurs after rst_n deasserts.
- halted = (state==IDLE).

Test Plan:
- Reset then run=1, opcode=0x00, mem_ready=1 -> state sequence 1,2,7,8,1. reg_write=1 and reg_dst=1 only in ALUWB. instr_count=1 after 4 cycles.
- lw (0x23) with mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles with iord=1 and mem_read=1; mem_to_reg=1 in MEMWB; 7 cycles total.
- sw (0x2B) -> mem_write=1 only in MEMWR; reg_write never 1; instr_count increments by 1.
- beq (0x04) then j (0x02) -> BRANCH asserts branch=1, alu_op=01, pc_src=01; JUMP asserts pc_write=1, pc_src=10; both take 3 cycles.
- opcode=0x3F -> illegal_op=1 for exactly 1 cycle in DECODE; next state FETCH; instr_count unchanged.
- run dropped during EXEC, then rst_n pulsed low mid-FETCH -> ALUWB completes, state goes to IDLE with halted=1; on reset all outputs are 0 and instr_count=0 asynchronously.
